// File: rtl/ascii_load_sched_if.sv
`default_nettype none
// =====================================================================
// ascii_load_sched_if : byte-stream bundle (HPS ioctl, UART, ACIA side)
// Revision            : 1.0
// =====================================================================
interface ascii_load_sched_if;
    logic       ioctl_download;
    logic       ioctl_wr;
    logic [7:0] ioctl_data;
    logic       ioctl_wait;
    logic       uart_valid;
    logic [7:0] uart_data;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;

    modport master (
        output ioctl_download, ioctl_wr, ioctl_data,
        output uart_valid, uart_data, out_ready,
        input  ioctl_wait, out_valid, out_data
    );

    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_data,
        input  uart_valid, uart_data, out_ready,
        output ioctl_wait, out_valid, out_data
    );
endinterface

`default_nettype wire

// File: rtl/ascii_load_sched.sv
`default_nettype none
// =====================================================================
// ascii_load_sched : paces HPS file bytes (FIFO + char/line gaps) or
//                    passes UART bytes into the ACIA receive path.
// Option macro     : LOAD_LF_STRIP_EN discards file 0x0A bytes on write.
// Revision         : 1.0
// =====================================================================
module ascii_load_sched #(
    parameter int FIFO_AW  = 4,
    parameter int CHAR_GAP = 24000,
    parameter int LINE_GAP = 960000,
    parameter int GAP_W    = 24
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              load_from,
    ascii_load_sched_if.slave bus,
    output logic              busy,
    output logic [7:0]        dropped
);

    localparam int CW    = FIFO_AW + 1;
    localparam int DEPTH = 1 << FIFO_AW;

    localparam logic [CW-1:0]    c_DEPTH    = CW'(DEPTH);
    localparam logic [CW-1:0]    c_WAIT_LVL = CW'(DEPTH - 1);
    localparam logic [GAP_W-1:0] c_CHAR_GAP = GAP_W'(CHAR_GAP);
    localparam logic [GAP_W-1:0] c_LINE_GAP = GAP_W'(LINE_GAP);
    localparam logic [GAP_W-1:0] c_GAP_ONE  = GAP_W'(1);

    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_FILE_SEND = 2'd1;
    localparam logic [1:0] c_FILE_GAP  = 2'd2;
    localparam logic [1:0] c_UART_PASS = 2'd3;

    logic [1:0]         r_state;
    logic [7:0]         r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [CW-1:0]      r_count;
    logic               r_ioctl_wait;
    logic               r_hold_full;
    logic [7:0]         r_hold_data;
    logic               r_out_valid;
    logic [7:0]         r_out_data;
    logic [GAP_W-1:0]   r_gap;
    logic [7:0]         r_dropped;

    logic               w_lf_strip;
    logic               w_file_wr;
    logic               w_full;
    logic               w_fifo_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_file_drop;
    logic [CW-1:0]      w_count_next;
    logic               w_hs;
    logic               w_uart_cap;
    logic               w_hold_clr;
    logic               w_uart_drop;
    logic [8:0]         w_drop_sum;
    logic [7:0]         w_head;
    logic               w_gap_done;

`ifdef LOAD_LF_STRIP_EN
    assign w_lf_strip = (bus.ioctl_data == 8'h0A);
`else
    assign w_lf_strip = 1'b0;
`endif

    assign w_file_wr    = bus.ioctl_wr & bus.ioctl_download & ~load_from & ~w_lf_strip;
    assign w_full       = (r_count == c_DEPTH);
    assign w_fifo_empty = (r_count == '0);
    assign w_hs         = r_out_valid & bus.out_ready;
    assign w_push       = w_file_wr & ~w_full;
    assign w_file_drop  = w_file_wr & w_full;
    assign w_pop        = (r_state == c_FILE_SEND) & w_hs;
    assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);
    assign w_head       = r_mem[r_rd_ptr];

    assign w_uart_cap   = bus.uart_valid & load_from;
    assign w_hold_clr   = (r_state == c_UART_PASS) & w_hs;
    assign w_uart_drop  = w_uart_cap & r_hold_full & ~w_hold_clr;
    assign w_drop_sum   = {1'b0, r_dropped} + 9'(w_file_drop) + 9'(w_uart_drop);

    // r_gap counts the idle cycles still to go, including the current one
    assign w_gap_done   = (r_gap <= c_GAP_ONE);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.ioctl_data;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_ioctl_wait <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count      <= w_count_next;
            // registered on the next count so one in-flight HPS write still fits
            r_ioctl_wait <= (w_count_next >= c_WAIT_LVL);
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_hold_full <= 1'b0;
            r_hold_data <= 8'h00;
        end else if (w_uart_cap && (!r_hold_full || w_hold_clr)) begin
            r_hold_full <= 1'b1;
            r_hold_data <= bus.uart_data;
        end else if (w_hold_clr) begin
            r_hold_full <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_dropped <= 8'h00;
        end else begin
            r_dropped <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state     <= c_IDLE;
            r_out_valid <= 1'b0;
            r_out_data  <= 8'h00;
            r_gap       <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (!load_from && !w_fifo_empty) begin
                        r_state     <= c_FILE_SEND;
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_head;
                    end else if (load_from && r_hold_full) begin
                        r_state     <= c_UART_PASS;
                        r_out_valid <= 1'b1;
                        r_out_data  <= r_hold_data;
                    end
                end
                c_FILE_SEND: begin
                    if (bus.out_ready) begin
                        r_state     <= c_FILE_GAP;
                        r_out_valid <= 1'b0;
                        r_gap       <= (r_out_data == 8'h0D) ? c_LINE_GAP : c_CHAR_GAP;
                    end
                end
                c_FILE_GAP: begin
                    if (w_gap_done) begin
                        if (!w_fifo_empty) begin
                            r_state     <= c_FILE_SEND;
                            r_out_valid <= 1'b1;
                            r_out_data  <= w_head;
                        end else begin
                            r_state <= c_IDLE;
                        end
                    end else begin
                        r_gap <= r_gap - c_GAP_ONE;
                    end
                end
                c_UART_PASS: begin
                    if (bus.out_ready) begin
                        r_state     <= c_IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= c_IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ioctl_wait = r_ioctl_wait;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_data   = r_out_data;
    assign busy           = (r_state != c_IDLE);
    assign dropped        = r_dropped;

endmodule

`default_nettype wire

// File: tb/tb_ascii_load_sched.sv
`default_nettype none
// =====================================================================
// tb_ascii_load_sched : directed + random stimulus against a timestamp
//                       reference model of the load scheduler.
// Revision            : 1.0
// =====================================================================
module tb_ascii_load_sched;

    localparam int DEPTH = 16;
    localparam int CG    = 4;
    localparam int LG    = 16;

    logic       clk     = 1'b0;
    logic       n_reset = 1'b1;
    logic       load_from;
    logic       busy;
    logic [7:0] dropped;

    ascii_load_sched_if bus();

    ascii_load_sched #(
        .FIFO_AW  (4),
        .CHAR_GAP (CG),
        .LINE_GAP (LG),
        .GAP_W    (24)
    ) dut (
        .clk       (clk),
        .n_reset   (n_reset),
        .load_from (load_from),
        .bus       (bus),
        .busy      (busy),
        .dropped   (dropped)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int edge_no  = 0;

    // reference model: byte queues plus the edge at which pacing ends
    byte unsigned mq[$];
    bit           m_hold_full;
    byte unsigned m_hold;
    bit           m_valid;
    bit           m_busy;
    bit           m_uart;
    byte unsigned m_data;
    int           m_wake;
    int           m_drop;

    byte unsigned dut_log[$];
    int           dut_hs[$];
    int           busy_fall;
    bit           prev_busy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_hold_full = 0; m_hold = 0;
        m_valid = 0; m_busy = 0; m_uart = 0; m_data = 0;
        m_wake = 0; m_drop = 0;
        dut_log.delete(); dut_hs.delete();
        busy_fall = -1; prev_busy = 0;
    endtask

    task automatic step(input bit ld, input bit dl, input bit wr, input byte unsigned wd,
                        input bit uv, input byte unsigned ud, input bit rdy);
        bit pre_full;
        bit lf;
        load_from          = ld;
        bus.ioctl_download = dl;
        bus.ioctl_wr       = wr;
        bus.ioctl_data     = wd;
        bus.uart_valid     = uv;
        bus.uart_data      = ud;
        bus.out_ready      = rdy;
        if (bus.out_valid && rdy) begin
            dut_log.push_back(bus.out_data);
            dut_hs.push_back(edge_no);
        end
        @(posedge clk);
        edge_no++;
        pre_full = (mq.size() == DEPTH);
        if (m_valid) begin
            if (rdy) begin
                m_valid = 0;
                if (m_uart) begin
                    m_hold_full = 0;
                    m_busy      = 0;
                end else begin
                    void'(mq.pop_front());
                    m_wake = edge_no + ((m_data == 8'h0D) ? LG : CG);
                end
            end
        end else if (m_busy) begin
            if (edge_no == m_wake) begin
                if (mq.size() > 0) begin
                    m_valid = 1;
                    m_data  = mq[0];
                end else begin
                    m_busy = 0;
                end
            end
        end else begin
            if (!ld && mq.size() > 0) begin
                m_valid = 1; m_busy = 1; m_uart = 0; m_data = mq[0];
            end else if (ld && m_hold_full) begin
                m_valid = 1; m_busy = 1; m_uart = 1; m_data = m_hold;
            end
        end
        lf = 0;
`ifdef LOAD_LF_STRIP_EN
        lf = (wd == 8'h0A);
`endif
        if (wr && dl && !ld && !lf) begin
            if (pre_full) m_drop++;
            else          mq.push_back(wd);
        end
        if (uv && ld) begin
            if (m_hold_full) m_drop++;
            else begin
                m_hold_full = 1;
                m_hold      = ud;
            end
        end
        if (m_drop > 255) m_drop = 255;
        @(negedge clk);
        chk("out_valid", bus.out_valid, m_valid);
        chk("busy", busy, m_busy);
        chk("dropped", dropped, m_drop);
        chk("ioctl_wait", bus.ioctl_wait, mq.size() >= DEPTH - 1);
        if (m_valid) chk("out_data", bus.out_data, m_data);
        if (prev_busy && !busy) busy_fall = edge_no;
        prev_busy = busy;
    endtask

    task automatic idle(input int n, input bit ld, input bit rdy);
        repeat (n) step(ld, 0, 0, 8'h00, 0, 8'h00, rdy);
    endtask

    task automatic do_reset();
        load_from = 0; bus.ioctl_download = 0; bus.ioctl_wr = 0; bus.ioctl_data = 0;
        bus.uart_valid = 0; bus.uart_data = 0; bus.out_ready = 0;
        n_reset = 0;
        #1;
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_dropped", dropped, 8'h00);
        chk("rst_ioctl_wait", bus.ioctl_wait, 1'b0);
        chk("rst_out_data", bus.out_data, 8'h00);
        model_clear();
        @(negedge clk);
        n_reset = 1;
    endtask

    task automatic chk_log(input string tag, input byte unsigned exp[$]);
        chk({tag, "_len"}, dut_log.size(), exp.size());
        foreach (exp[i]) begin
            if (i < dut_log.size()) chk(tag, dut_log[i], exp[i]);
        end
    endtask

    initial begin
        byte unsigned e[$];
        bit           rld;
        load_from = 0; bus.ioctl_download = 0; bus.ioctl_wr = 0; bus.ioctl_data = 0;
        bus.uart_valid = 0; bus.uart_data = 0; bus.out_ready = 0;
        #2;
        do_reset();

        // "10 A\r" with short gaps: spacing and line-gap tail
        e = '{8'h31, 8'h30, 8'h20, 8'h41, 8'h0D};
        foreach (e[i]) step(0, 1, 1, e[i], 0, 8'h00, 1);
        idle(50, 0, 1);
        chk_log("t1_bytes", e);
        for (int i = 1; i < dut_hs.size(); i++) chk("t1_spacing", dut_hs[i] - dut_hs[i-1], 5);
        if (dut_hs.size() > 0) chk("t1_busy_clear", busy_fall - dut_hs[dut_hs.size()-1], 17);

        // burst of 20 into a 16-deep FIFO with the ACIA stalled
        do_reset();
        for (int i = 1; i <= 20; i++) step(0, 1, 1, 8'(i), 0, 8'h00, 0);
        chk("t2_dropped", dropped, 8'd4);
        chk("t2_wait", bus.ioctl_wait, 1'b1);
        idle(100, 0, 1);
        e.delete();
        for (int i = 1; i <= 16; i++) e.push_back(8'(i));
        chk_log("t2_bytes", e);

        // UART holding register collision
        do_reset();
        step(1, 0, 0, 8'h00, 1, 8'h41, 0);
        step(1, 0, 0, 8'h00, 1, 8'h42, 0);
        idle(3, 1, 0);
        chk("t3_out_data", bus.out_data, 8'h41);
        chk("t3_dropped", dropped, 8'd1);
        idle(4, 1, 1);
        e = '{8'h41};
        chk_log("t3_bytes", e);

        // source switch during file drain
        do_reset();
        step(0, 1, 1, 8'h31, 0, 8'h00, 1);
        step(0, 1, 1, 8'h32, 0, 8'h00, 1);
        step(0, 1, 1, 8'h33, 0, 8'h00, 1);
        step(0, 1, 1, 8'h34, 0, 8'h00, 1);
        step(1, 0, 0, 8'h00, 0, 8'h00, 1);
        step(1, 0, 0, 8'h00, 1, 8'h55, 1);
        step(1, 0, 0, 8'h00, 1, 8'h66, 1);
        idle(40, 1, 1);
        e = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h55};
        chk_log("t4_bytes", e);
        chk("t4_dropped", dropped, 8'd1);

        // reset in the middle of a gap with bytes queued
        do_reset();
        for (int i = 0; i < 6; i++) step(0, 1, 1, 8'(8'h61 + i), 0, 8'h00, 1);
        do_reset();
        idle(30, 0, 1);
        chk("t5_no_output", dut_log.size(), 0);

        // LF handling
        do_reset();
        e = '{8'h41, 8'h0D, 8'h0A, 8'h42};
        foreach (e[i]) step(0, 1, 1, e[i], 0, 8'h00, 1);
        idle(60, 0, 1);
`ifdef LOAD_LF_STRIP_EN
        e = '{8'h41, 8'h0D, 8'h42};
`else
        e = '{8'h41, 8'h0D, 8'h0A, 8'h42};
`endif
        chk_log("t6_bytes", e);
        chk("t6_dropped", dropped, 8'd0);

        // randomised mix against the model
        do_reset();
        rld = 0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 39) == 0) rld = ~rld;
            step(rld, $urandom_range(0, 7) != 0, $urandom_range(0, 2) == 0, 8'($urandom),
                 $urandom_range(0, 5) == 0, 8'($urandom), $urandom_range(0, 3) != 0);
        end

        // dropped counter saturation
        do_reset();
        for (int i = 0; i < 280; i++) step(0, 1, 1, 8'($urandom), 0, 8'h00, 0);
        chk("t8_saturate", dropped, 8'd255);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
